// File: rtl/mpsoc_msi_wb_burst_master.sv
// mpsoc_msi_wb_burst_master: Wishbone B3 initiator running one classic cycle or registered-feedback burst per command
module mpsoc_msi_wb_burst_master #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  output logic            rdat_valid_o,
  output logic [DW-1:0]   rdat_o,
  output logic            done_o,
  output logic [1:0]      status_o,
  output logic [LW:0]     beats_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  input  logic [DW-1:0]   wb_dat_i
);
  localparam int BW = DW / 8;
  localparam int AB = $clog2(BW);
  typedef enum logic [1:0] {IDLE, WDATA, BUS, DONE} state_e;
  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW:0]       cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wdat_ready_q, wdat_ready_d;
  logic              rdat_valid_q, rdat_valid_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [LW:0]       beats_q, beats_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [BW-1:0]     sel_q, sel_d;
  logic              we_q, we_d;
  logic [2:0]        cti_q, cti_d;
  logic [1:0]        bte_q, bte_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [AW-1:0]     adr_inc, adr_mask, adr_nxt;
  assign cmd_ready_o  = cmd_ready_q;
  assign wdat_ready_o = wdat_ready_q;
  assign rdat_valid_o = rdat_valid_q;
  assign rdat_o       = rdat_q;
  assign done_o       = done_q;
  assign status_o     = status_q;
  assign beats_o      = beats_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign wb_we_o      = we_q;
  assign wb_cti_o     = cti_q;
  assign wb_bte_o     = bte_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  // next beat address: plain increment, or increment confined to the aligned wrap block
  always_comb begin
    adr_inc  = adr_q + AW'(BW);
    adr_mask = (bte_q == 2'b00) ? '1 : AW'(((2 << bte_q) - 1) << AB);
    adr_nxt  = (adr_q & ~adr_mask) | (adr_inc & adr_mask);
  end
  // sequencing of command, write data and bus beats; outputs decoded from the next state
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    rdat_valid_d = 1'b0;
    rdat_d       = rdat_q;
    status_d     = status_q;
    beats_d      = beats_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    bte_d        = bte_q;
    case (state_q)
      IDLE: if (cmd_valid_i && cmd_ready_q) begin
        we_d    = cmd_we_i;
        adr_d   = cmd_adr_i;
        len_d   = cmd_len_i;
        bte_d   = cmd_bte_i;
        sel_d   = cmd_sel_i;
        cnt_d   = '0;
        state_d = cmd_we_i ? WDATA : BUS;
      end
      WDATA: if (wdat_valid_i && wdat_ready_q) begin
        dat_d   = wdat_i;
        state_d = BUS;
      end
      BUS: if (wb_err_i || wb_rty_i) begin
        status_d = wb_err_i ? 2'b01 : 2'b10;
        beats_d  = cnt_q;
        state_d  = DONE;
      end else if (wb_ack_i) begin
        cnt_d        = cnt_q + (LW+1)'(1);
        adr_d        = adr_nxt;
        rdat_d       = we_q ? rdat_q : wb_dat_i;
        rdat_valid_d = !we_q;
        status_d     = (cnt_q == {1'b0, len_q}) ? 2'b00 : status_q;
        beats_d      = (cnt_q == {1'b0, len_q}) ? cnt_d : beats_q;
        state_d      = (cnt_q == {1'b0, len_q}) ? DONE : we_q ? WDATA : BUS;
      end
      DONE: state_d = IDLE;
    endcase
    cmd_ready_d  = state_d == IDLE;
    wdat_ready_d = state_d == WDATA;
    done_d       = state_d == DONE;
    stb_d        = state_d == BUS;
    cyc_d        = (state_d == BUS) || (state_d == WDATA && cyc_q);
    cti_d        = (state_d != BUS || len_d == '0) ? 3'b000 :
                   (cnt_d == {1'b0, len_d}) ? 3'b111 : 3'b010;
  end
  // state and registered outputs; reset drops the bus cycle immediately
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      wdat_ready_q <= 1'b0;
      rdat_valid_q <= 1'b0;
      rdat_q       <= '0;
      done_q       <= 1'b0;
      status_q     <= '0;
      beats_q      <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cti_q        <= '0;
      bte_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      wdat_ready_q <= wdat_ready_d;
      rdat_valid_q <= rdat_valid_d;
      rdat_q       <= rdat_d;
      done_q       <= done_d;
      status_q     <= status_d;
      beats_q      <= beats_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cti_q        <= cti_d;
      bte_q        <= bte_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
    end
  end
endmodule

// File: tb/tb_mpsoc_msi_wb_burst_master.sv
// tb_mpsoc_msi_wb_burst_master: randomized bench with an in-bench slave and reference model
module tb_mpsoc_msi_wb_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 8;
  logic            clk = 1'b0;
  logic            wb_rst_ni;
  logic            cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0]   cmd_adr_i;
  logic [LW-1:0]   cmd_len_i;
  logic [1:0]      cmd_bte_i;
  logic [DW/8-1:0] cmd_sel_i;
  logic            wdat_valid_i, wdat_ready_o;
  logic [DW-1:0]   wdat_i;
  logic            rdat_valid_o;
  logic [DW-1:0]   rdat_o;
  logic            done_o;
  logic [1:0]      status_o;
  logic [LW:0]     beats_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic            wb_cyc_o, wb_stb_o;
  logic            wb_ack_i, wb_err_i, wb_rty_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wd [256];
  logic [DW-1:0]   rd [256];
  logic [1:0]      last_st;
  int              last_beats;
  int              n_vec = 0;
  int              n_err = 0;
  mpsoc_msi_wb_burst_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(wb_rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i), .cmd_sel_i(cmd_sel_i),
    .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat_i),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .done_o(done_o),
    .status_o(status_o), .beats_o(beats_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // expected byte address of beat i: linear, or wrapping inside an aligned block of 4/8/16 words
  function automatic logic [AW-1:0] exp_adr(input logic [AW-1:0] base, input int i, input logic [1:0] bte);
    longint unsigned blk, b;
    b = longint'(base);
    if (bte == 2'b00) return AW'(b + 4 * i);
    blk = 4 * (2 << bte);
    return AW'((b / blk) * blk + ((b % blk) + 4 * i) % blk);
  endfunction
  task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [LW-1:0] len,
                         input logic [1:0] bte, input logic [DW/8-1:0] sel, input int err_at,
                         input int rty_at, input bit both, input int waits, input int gap, input int rst_at);
    int stop, nb, beat, widx, pulses, wcnt, wneed, t;
    logic [1:0] est;
    bit fin;
    stop = int'(len) + 1;
    est = 2'b00;
    if (rty_at >= 0 && rty_at <= int'(len)) begin stop = rty_at; est = 2'b10; end
    if (err_at >= 0 && err_at <= int'(len) && err_at <= stop) begin stop = err_at; est = 2'b01; end
    nb = stop;
    chk("status_hold", status_o, last_st);
    chk("beats_hold", beats_o, last_beats);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_bte_i = bte; cmd_sel_i = sel;
    t = 0;
    while (!cmd_ready_o && t < 50) begin @(negedge clk); t++; end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    beat = 0; widx = 0; pulses = 0; fin = 0; wcnt = 0;
    wneed = waits >= 0 ? waits : int'($urandom_range(0, 3));
    for (int c = 0; c < 3000 && !fin; c++) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wdat_valid_i = 1'b0;
      if (rdat_valid_o) begin chk("rdat", rdat_o, rd[pulses & 255]); pulses++; end
      if (done_o) begin
        fin = 1;
        chk("status", status_o, est);
        chk("beats", beats_o, nb);
        chk("cyc_at_done", wb_cyc_o, 0);
        if (!we && waits == 0 && est == 2'b00) chk("latency", c, int'(len) + 1);
      end else if (wdat_ready_o) begin
        chk("gap_stb", wb_stb_o, 0);
        chk("gap_cyc", wb_cyc_o, beat > 0);
        wdat_i = wd[widx & 255];
        wdat_valid_i = ($urandom_range(0, gap) == 0);
        if (wdat_valid_i) widx++;
      end else if (wb_stb_o) begin
        if (rst_at == beat) begin
          wb_rst_ni = 1'b0;
          #1;
          chk("rst_cyc", wb_cyc_o, 0);
          chk("rst_stb", wb_stb_o, 0);
          chk("rst_cti", wb_cti_o, 0);
          repeat (3) begin @(negedge clk); chk("rst_no_done", done_o, 0); end
          wb_rst_ni = 1'b1;
          @(negedge clk);
          last_st = 2'b00; last_beats = 0;
          return;
        end
        chk("adr", wb_adr_o, exp_adr(adr, beat, bte));
        chk("cti", wb_cti_o, len == 0 ? 3'b000 : beat == int'(len) ? 3'b111 : 3'b010);
        chk("cyc", wb_cyc_o, 1);
        chk("we", wb_we_o, we);
        chk("sel", wb_sel_o, sel);
        chk("bte", wb_bte_o, bte);
        if (we) chk("wdat", wb_dat_o, wd[beat & 255]);
        wb_dat_i = rd[beat & 255];
        if (wcnt < wneed) wcnt++;
        else begin
          wcnt = 0;
          wneed = waits >= 0 ? waits : int'($urandom_range(0, 3));
          if (beat == err_at) begin wb_err_i = 1'b1; wb_rty_i = (beat == rty_at); wb_ack_i = both; end
          else if (beat == rty_at) begin wb_rty_i = 1'b1; wb_ack_i = both; end
          else begin wb_ack_i = 1'b1; beat++; end
        end
      end
      @(negedge clk);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wdat_valid_i = 1'b0;
    chk("finished", fin, 1);
    chk("pulses", pulses, we ? 0 : nb);
    chk("done_one_cycle", done_o, 0);
    chk("ready_after_done", cmd_ready_o, 1);
    last_st = est; last_beats = nb;
  endtask
  task automatic fill(input bit seq);
    for (int i = 0; i < 256; i++) begin
      wd[i] = seq ? DW'(32'hA0 + i) : DW'($urandom);
      rd[i] = DW'($urandom);
    end
  endtask
  initial begin
    logic we;
    logic [LW-1:0] len;
    int ea, ra;
    wb_rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
    cmd_bte_i = '0; cmd_sel_i = '0; wdat_valid_i = 1'b0; wdat_i = '0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    last_st = 2'b00; last_beats = 0;
    #12;
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_cyc0", wb_cyc_o, 0);
    chk("rst_stb0", wb_stb_o, 0);
    chk("rst_cti0", wb_cti_o, 0);
    chk("rst_done0", done_o, 0);
    chk("rst_rvalid", rdat_valid_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_beats", beats_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_wready", wdat_ready_o, 0);
    @(negedge clk);
    wb_rst_ni = 1'b1;
    @(negedge clk);
    fill(0); run_cmd(0, 32'h100, 8'd0, 2'b00, 4'hF, -1, -1, 0, 2, 0, -1);
    fill(1); run_cmd(1, 32'h0, 8'd3, 2'b00, 4'hF, -1, -1, 0, 0, 2, -1);
    fill(0); run_cmd(0, 32'h18, 8'd3, 2'b01, 4'hF, -1, -1, 0, 0, 0, -1);
    fill(0); run_cmd(0, 32'h200, 8'd7, 2'b00, 4'hF, 2, -1, 0, 0, 0, -1);
    fill(0); run_cmd(0, 32'h300, 8'd3, 2'b00, 4'hF, -1, 0, 1, 0, 0, -1);
    fill(0); run_cmd(0, 32'h400, 8'd7, 2'b00, 4'hF, -1, -1, 0, 0, 0, 3);
    fill(0); run_cmd(0, 32'h400, 8'd7, 2'b10, 4'h3, -1, -1, 0, 0, 0, -1);
    fill(0); run_cmd(1, 32'hFFFF_FFF8, 8'd3, 2'b00, 4'h5, -1, -1, 0, -1, 1, -1);
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1));
      len = LW'($urandom_range(0, 15));
      ea  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      ra  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      fill(0);
      run_cmd(we, AW'($urandom) & ~AW'(3), len, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
              ea, ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 0 : -1,
              int'($urandom_range(0, 2)), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
